wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 5-stage pipeline, directly downstream of the memory stage and its MEM/WB latch. Selects the memory load data or the forwarded ALU result per the ALU/MEM select signal, writes it into the 8 x 16-bit architectural register file, and serves the two decode-stage read ports. It also presents a registered copy of the last write for EX-stage forwarding, and keeps a retired-instruction counter.

## Interface
- DATA_W, 16, datapath and register width
- REG_N, 8, number of architectural registers
- REG_AW, 3, register address width (log2 REG_N)
- CLOCK_50  input  1  single clock, all state updates on its rising edge
- RESET  input  1  synchronous, active-high reset
- WBVALID  input  1  MEM/WB latch holds a valid instruction this cycle
- ALUMEMSIG  input  1  1 = write memory data, 0 = write ALU result
- MEMDATA  input  DATA_W  load data from MEM/WB latch
- ALUDATA  input  DATA_W  ALU result from MEM/WB latch
- WBREG  input  REG_AW  destination register
- REGWRITE  input  1  instruction writes a register
- RADDRA, RADDRB  input  REG_AW  decode-stage read addresses
- RDATAA, RDATAB  output  DATA_W  read data, combinational from the array
- WBDATA  output  DATA_W  registered value of the last write, for EX forwarding
- WBREGOUT  output  REG_AW  registered destination of the last write
- WBEN  output  1  registered; 1 when WBDATA/WBREGOUT describe a committed write
- RETIRED  output  16  count of retired instructions

## Operation
- Selected value is SEL = ALUMEMSIG ? MEMDATA : ALUDATA. It is purely combinational.
- A write commits when WBVALID & REGWRITE & (WBREG != 0) & !RESET. SEL is stored into reg[WBREG] at the rising edge.
- R0 is hardwired to zero:
  - Reads of address 0 return 0.
  - Writes to R0 are discarded and leave WBEN at 0.
- Forwarding registers update every cycle: WBEN <= commit, WBDATA <= SEL, WBREGOUT <= WBREG.
  - When no write commits, WBDATA and WBREGOUT hold their previous values.
- RETIRED increments by 1 on every non-reset cycle with WBVALID = 1, regardless of REGWRITE or destination.
  - It wraps from 0xFFFF to 0x0000 with no flag.
- Reset:
  - RESET has priority over every other input.
  - All 8 registers are cleared to 0, and WBDATA, WBREGOUT, WBEN and RETIRED are set to 0.
  - RDATAA/RDATAB therefore read 0 from the cycle after reset.
  - A write presented in a reset cycle is lost, and is not replayed after reset.
- Simultaneous read and write of the same register: behaviour is set by WB_BYPASS_EN (see Configuration).

## Timing
- Write latency: 1 edge. The value is visible in the array from the cycle after commit.
- Read latency: 0 cycles. RDATA follows RADDR and the array combinationally.
- WBEN/WBDATA/WBREGOUT are valid exactly one cycle after the commit cycle, and are asserted for one cycle per commit.
- Back-to-back writes to the same register on consecutive cycles: each one commits, and the last one wins.
- There is no stall input. The upstream latch presents one instruction per cycle, and WBVALID = 0 is a bubble.

## Configuration
- WB_BYPASS_EN defined:
  - A read port whose address equals WBREG in a commit cycle returns SEL combinationally (write-through), covering the WB to ID hazard.
  - Address 0 still returns 0.
- WB_BYPASS_EN undefined:
  - Read ports return the pre-write array contents during the commit cycle.
  - The new value appears from the next cycle, and the hazard is left to the pipeline's stall logic.

## Structure
- Shared package pipe_pkg holds:
  - DATA_W, REG_N and REG_AW constants.
  - An ALU/MEM select encoding (SEL_ALU = 0, SEL_MEM = 1), shared with the memory stage latch.
- One sub-module, regfile:
  - Contains the 8-entry array with synchronous clear, one write port and two combinational read ports.
  - The R0 rule and the optional bypass are implemented inside it.
- The top level holds the select mux, the forwarding registers and the RETIRED counter.

## Test plan
- Reset then ALU write:
  - Stimulus: RESET for 2 cycles, then WBVALID = 1, REGWRITE = 1, ALUMEMSIG = 0, ALUDATA = 0x1234, WBREG = 3.
  - Response: next cycle RDATAA (RADDRA = 3) = 0x1234, WBEN = 1, WBREGOUT = 3, WBDATA = 0x1234, RETIRED = 1.
- Load write:
  - Stimulus: ALUMEMSIG = 1, MEMDATA = 0xBEEF, ALUDATA = 0x0001, WBREG = 5.
  - Response: reg 5 reads 0xBEEF, never 0x0001.
- R0 protection:
  - Stimulus: write 0xFFFF to WBREG = 0.
  - Response: RDATAB (RADDRB = 0) = 0 and WBEN = 0 next cycle, while RETIRED still increments.
- Same-cycle read/write:
  - Setup: reg 2 = 0x0AAA. Stimulus: RADDRA = 2 while committing 0x5555 to reg 2.
  - Response: RDATAA = 0x5555 in that cycle with WB_BYPASS_EN defined, 0x0AAA without it. Both builds read 0x5555 the next cycle.
- Bubbles and wrap:
  - Stimulus: WBVALID = 0 for 10 cycles, then preload RETIRED to 0xFFFF via 65535 valid cycles plus one more.
  - Response: no change during the bubbles, then RETIRED = 0x0000.
- Reset mid-write:
  - Stimulus: RESET = 1 in the same cycle as a commit of 0x7777 to reg 4.
  - Response: reg 4 = 0, WBEN = 0, RETIRED = 0 after the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions used by the write-back stage and the memory
// stage latch: datapath/register-file geometry and the ALU/MEM select code.
//   DATA_W  : datapath and register width
//   REG_N   : number of architectural registers
//   REG_AW  : register address width
//   alumem_sel_e : ALUMEMSIG encoding (SEL_ALU = 0, SEL_MEM = 1)
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int REG_AW = 3;

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } alumem_sel_e;

endpackage

// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// MEM/WB latch bundle presented to the write-back stage.
//   WBVALID   : latch holds a valid instruction this cycle
//   ALUMEMSIG : 1 = write memory data, 0 = write ALU result
//   MEMDATA   : load data
//   ALUDATA   : ALU result
//   WBREG     : destination register
//   REGWRITE  : instruction writes a register
// Modports: master (memory-stage latch side), slave (write-back stage side).
// ---------------------------------------------------------------------------
interface wb_stage_if;
    import pipe_pkg::*;

    logic              WBVALID;
    logic              ALUMEMSIG;
    logic [DATA_W-1:0] MEMDATA;
    logic [DATA_W-1:0] ALUDATA;
    logic [REG_AW-1:0] WBREG;
    logic              REGWRITE;

    modport master (
        output WBVALID, ALUMEMSIG, MEMDATA, ALUDATA, WBREG, REGWRITE
    );

    modport slave (
        input  WBVALID, ALUMEMSIG, MEMDATA, ALUDATA, WBREG, REGWRITE
    );

endinterface

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 8 x 16-bit architectural register file: synchronous clear, one write port,
// two combinational read ports. R0 is hardwired to zero (no storage).
// Optional macro WB_BYPASS_EN: a read of the address being written in the
// same cycle returns the write data (write-through). Without it, reads see
// the pre-write contents until the next cycle.
// Ports:
//   clk, srst           : clock, synchronous active-high clear
//   we, waddr, wdata    : write port (we must already exclude R0 and reset)
//   raddr_a/b, rdata_a/b: combinational read ports
// ---------------------------------------------------------------------------
module regfile
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_N];

    generate
        for (genvar gi = 0; gi < REG_N; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // R0 has no storage; it always reads as zero.
                assign regs[gi] = '0;
            end else begin : g_ff
                logic [DATA_W-1:0] r_q;
                logic [DATA_W-1:0] r_d;

                always_comb begin
                    r_d = r_q;
                    if (we && (waddr == REG_AW'(gi))) begin
                        r_d = wdata;
                    end
                end

                always_ff @(posedge clk) begin
                    if (srst) begin
                        r_q <= '0;
                    end else begin
                        r_q <= r_d;
                    end
                end

                assign regs[gi] = r_q;
            end
        end
    endgenerate

    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
`ifdef WB_BYPASS_EN
        // Write-through closes the WB -> ID hazard without a stall.
        if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
`endif
        // Address 0 wins over any bypass.
        if (raddr_a == '0) begin
            rdata_a = '0;
        end
        if (raddr_b == '0) begin
            rdata_b = '0;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage: selects load data or ALU result, writes it into the
// register file, serves the two decode read ports, keeps a registered copy of
// the last committed write for EX forwarding and counts retired instructions.
// Optional macro WB_BYPASS_EN enables same-cycle write-through on the read
// ports (implemented inside regfile).
// Ports:
//   CLOCK_50, RESET      : clock, synchronous active-high reset
//   mw                   : MEM/WB latch bundle (wb_stage_if.slave)
//   RADDRA/B, RDATAA/B   : decode-stage read ports (combinational)
//   WBDATA, WBREGOUT,WBEN: registered last-write info for forwarding
//   RETIRED              : 16-bit wrapping retired-instruction counter
// ---------------------------------------------------------------------------
module wb_stage
    import pipe_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              RESET,
    wb_stage_if.slave         mw,
    input  logic [REG_AW-1:0] RADDRA,
    input  logic [REG_AW-1:0] RADDRB,
    output logic [DATA_W-1:0] RDATAA,
    output logic [DATA_W-1:0] RDATAB,
    output logic [DATA_W-1:0] WBDATA,
    output logic [REG_AW-1:0] WBREGOUT,
    output logic              WBEN,
    output logic [15:0]       RETIRED
);

    logic [DATA_W-1:0] sel;
    logic              commit;

    logic [DATA_W-1:0] wbdata_q,   wbdata_d;
    logic [REG_AW-1:0] wbregout_q, wbregout_d;
    logic              wben_q,     wben_d;
    logic [15:0]       retired_q,  retired_d;

    assign sel    = (mw.ALUMEMSIG == 1'(SEL_MEM)) ? mw.MEMDATA : mw.ALUDATA;
    // Writes to R0 never commit, so they also leave WBEN low.
    assign commit = mw.WBVALID & mw.REGWRITE & (mw.WBREG != '0) & ~RESET;

    regfile u_regfile (
        .clk     (CLOCK_50),
        .srst    (RESET),
        .we      (commit),
        .waddr   (mw.WBREG),
        .wdata   (sel),
        .raddr_a (RADDRA),
        .raddr_b (RADDRB),
        .rdata_a (RDATAA),
        .rdata_b (RDATAB)
    );

    always_comb begin
        wben_d     = commit;
        wbdata_d   = wbdata_q;
        wbregout_d = wbregout_q;
        // Forwarding data holds its last committed value between writes.
        if (commit) begin
            wbdata_d   = sel;
            wbregout_d = mw.WBREG;
        end
        // Every valid instruction retires, whatever it writes; wraps silently.
        retired_d = mw.WBVALID ? (retired_q + 16'd1) : retired_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wben_q     <= 1'b0;
            wbdata_q   <= '0;
            wbregout_q <= '0;
            retired_q  <= '0;
        end else begin
            wben_q     <= wben_d;
            wbdata_q   <= wbdata_d;
            wbregout_q <= wbregout_d;
            retired_q  <= retired_d;
        end
    end

    assign WBEN     = wben_q;
    assign WBDATA   = wbdata_q;
    assign WBREGOUT = wbregout_q;
    assign RETIRED  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage. Each driven cycle pushes the expected
// forwarding-register state onto a scoreboard queue; it is popped one edge
// later and compared inline by the scenario task. Build with or without
// +define+WB_BYPASS_EN; the same-cycle read expectation follows the macro.
// ---------------------------------------------------------------------------
module tb_wb_stage;
    import pipe_pkg::*;

    logic              CLOCK_50 = 1'b0;
    logic              RESET;
    logic [REG_AW-1:0] RADDRA, RADDRB;
    logic [DATA_W-1:0] RDATAA, RDATAB, WBDATA;
    logic [REG_AW-1:0] WBREGOUT;
    logic              WBEN;
    logic [15:0]       RETIRED;

    wb_stage_if bus ();

    wb_stage dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .mw       (bus),
        .RADDRA   (RADDRA),
        .RADDRB   (RADDRB),
        .RDATAA   (RDATAA),
        .RDATAB   (RDATAB),
        .WBDATA   (WBDATA),
        .WBREGOUT (WBREGOUT),
        .WBEN     (WBEN),
        .RETIRED  (RETIRED)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic              en;
        logic [REG_AW-1:0] r;
        logic [DATA_W-1:0] d;
        logic [15:0]       ret;
    } exp_t;

    exp_t              sb[$];
    exp_t              e;
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [15:0]       m_ret    = 16'd0;
    logic [DATA_W-1:0] last_d   = '0;
    logic [REG_AW-1:0] last_r   = '0;

    // Present one MEM/WB cycle and queue what the forwarding outputs must be
    // after the next edge.
    task automatic drive(input logic v, input logic rw, input logic s,
                         input logic [15:0] md, input logic [15:0] ad,
                         input logic [2:0] wr, input logic rst);
        logic c;
        RESET         = rst;
        bus.WBVALID   = v;
        bus.REGWRITE  = rw;
        bus.ALUMEMSIG = s;
        bus.MEMDATA   = md;
        bus.ALUDATA   = ad;
        bus.WBREG     = wr;
        c = !rst && v && rw && (wr != 3'd0);
        if (rst) begin
            last_d = '0; last_r = '0; m_ret = 16'd0;
        end else begin
            if (c) begin
                last_d = s ? md : ad;
                last_r = wr;
            end
            if (v) m_ret = m_ret + 16'd1;
        end
        sb.push_back('{c, last_r, last_d, m_ret});
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        n_checks++; if (WBEN !== 1'b0) begin n_fail++; $display("FAIL reset_wben got %0b exp 0", WBEN); end
        n_checks++; if (WBDATA !== 16'h0) begin n_fail++; $display("FAIL reset_wbdata got %h exp 0000", WBDATA); end
        n_checks++; if (WBREGOUT !== 3'd0) begin n_fail++; $display("FAIL reset_wbregout got %0d exp 0", WBREGOUT); end
        n_checks++; if (RETIRED !== 16'h0) begin n_fail++; $display("FAIL reset_retired got %h exp 0000", RETIRED); end
        for (int i = 0; i < REG_N; i++) begin
            RADDRA = 3'(i); #1;
            n_checks++; if (RDATAA !== 16'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h exp 0000", i, RDATAA); end
        end
        step();
        $display("reset: WBEN=%0b RETIRED=%h", WBEN, RETIRED);
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b1, SEL_ALU, 16'h0000, 16'h1234, 3'd3, 1'b0); step();
        RADDRA = 3'd3; #1;
        n_checks++; if (RDATAA !== 16'h1234) begin n_fail++; $display("FAIL alu_rdata got %h exp 1234", RDATAA); end
        n_checks++; if (WBEN !== 1'b1 || e.en !== 1'b1) begin n_fail++; $display("FAIL alu_wben got %0b exp 1", WBEN); end
        n_checks++; if (WBREGOUT !== 3'd3) begin n_fail++; $display("FAIL alu_wbregout got %0d exp 3", WBREGOUT); end
        n_checks++; if (WBDATA !== e.d) begin n_fail++; $display("FAIL alu_wbdata got %h exp %h", WBDATA, e.d); end
        n_checks++; if (RETIRED !== 16'd1) begin n_fail++; $display("FAIL alu_retired got %h exp 0001", RETIRED); end
        $display("alu write: r3=%h WBDATA=%h RETIRED=%h", RDATAA, WBDATA, RETIRED);
    endtask

    task automatic test_load_write();
        drive(1'b1, 1'b1, SEL_MEM, 16'hBEEF, 16'h0001, 3'd5, 1'b0); step();
        RADDRB = 3'd5; #1;
        n_checks++; if (RDATAB !== 16'hBEEF) begin n_fail++; $display("FAIL load_rdata got %h exp beef", RDATAB); end
        n_checks++; if (WBDATA !== e.d) begin n_fail++; $display("FAIL load_wbdata got %h exp %h", WBDATA, e.d); end
        n_checks++; if (WBREGOUT !== e.r) begin n_fail++; $display("FAIL load_wbregout got %0d exp %0d", WBREGOUT, e.r); end
        n_checks++; if (RETIRED !== e.ret) begin n_fail++; $display("FAIL load_retired got %h exp %h", RETIRED, e.ret); end
        $display("load write: r5=%h WBDATA=%h", RDATAB, WBDATA);
    endtask

    task automatic test_r0_protect();
        drive(1'b1, 1'b1, SEL_ALU, 16'h0000, 16'hFFFF, 3'd0, 1'b0); step();
        RADDRB = 3'd0; #1;
        n_checks++; if (RDATAB !== 16'h0) begin n_fail++; $display("FAIL r0_rdata got %h exp 0000", RDATAB); end
        n_checks++; if (WBEN !== e.en) begin n_fail++; $display("FAIL r0_wben got %0b exp %0b", WBEN, e.en); end
        n_checks++; if (WBDATA !== e.d) begin n_fail++; $display("FAIL r0_wbdata_hold got %h exp %h", WBDATA, e.d); end
        n_checks++; if (WBREGOUT !== e.r) begin n_fail++; $display("FAIL r0_wbregout_hold got %0d exp %0d", WBREGOUT, e.r); end
        n_checks++; if (RETIRED !== e.ret) begin n_fail++; $display("FAIL r0_retired got %h exp %h", RETIRED, e.ret); end
        $display("r0 write: r0=%h WBEN=%0b RETIRED=%h", RDATAB, WBEN, RETIRED);
    endtask

    task automatic test_same_cycle();
        logic [15:0] exp_now;
`ifdef WB_BYPASS_EN
        exp_now = 16'h5555;
`else
        exp_now = 16'h0AAA;
`endif
        drive(1'b1, 1'b1, SEL_ALU, 16'h0000, 16'h0AAA, 3'd2, 1'b0); step();
        drive(1'b1, 1'b1, SEL_MEM, 16'h5555, 16'h9999, 3'd2, 1'b0);
        RADDRA = 3'd2; RADDRB = 3'd0; #1;
        n_checks++; if (RDATAA !== exp_now) begin n_fail++; $display("FAIL same_cycle_rdata got %h exp %h", RDATAA, exp_now); end
        n_checks++; if (RDATAB !== 16'h0) begin n_fail++; $display("FAIL same_cycle_r0 got %h exp 0000", RDATAB); end
        step(); #1;
        n_checks++; if (RDATAA !== 16'h5555) begin n_fail++; $display("FAIL same_cycle_next got %h exp 5555", RDATAA); end
        n_checks++; if (WBDATA !== e.d) begin n_fail++; $display("FAIL same_cycle_wbdata got %h exp %h", WBDATA, e.d); end
        $display("same-cycle rd/wr: during=%h after=%h", exp_now, RDATAA);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, SEL_ALU, 16'h0, 16'h1111, 3'd6, 1'b0); step();
        n_checks++; if (WBDATA !== e.d || WBEN !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %h/%0b exp %h/1", WBDATA, WBEN, e.d); end
        drive(1'b1, 1'b1, SEL_MEM, 16'h2222, 16'h0, 3'd6, 1'b0); step();
        RADDRA = 3'd6; #1;
        n_checks++; if (WBDATA !== e.d || WBEN !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %h/%0b exp %h/1", WBDATA, WBEN, e.d); end
        n_checks++; if (RDATAA !== 16'h2222) begin n_fail++; $display("FAIL b2b_last_wins got %h exp 2222", RDATAA); end
        $display("back-to-back r6=%h", RDATAA);
    endtask

    task automatic test_bubbles_wrap();
        logic [15:0] ret0;
        ret0 = m_ret;
        for (int i = 0; i < 10; i++) begin
            // Bubble with REGWRITE high must still not write r1.
            drive(1'b0, 1'b1, SEL_ALU, 16'h0, 16'hDEAD, 3'd1, 1'b0); step();
            n_checks++; if (RETIRED !== ret0 || WBEN !== 1'b0) begin n_fail++; $display("FAIL bubble%0d got %h/%0b exp %h/0", i, RETIRED, WBEN, ret0); end
        end
        RADDRA = 3'd1; #1;
        n_checks++; if (RDATAA !== 16'h0) begin n_fail++; $display("FAIL bubble_r1 got %h exp 0000", RDATAA); end
        drive(1'b0, 1'b0, SEL_ALU, 16'h0, 16'h0, 3'd0, 1'b1); step();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, SEL_ALU, 16'h0, 16'h0, 3'd7, 1'b0); step();
        end
        n_checks++; if (RETIRED !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffff", RETIRED); end
        drive(1'b1, 1'b0, SEL_ALU, 16'h0, 16'h0, 3'd7, 1'b0); step();
        n_checks++; if (RETIRED !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h exp 0000", RETIRED); end
        $display("bubbles/wrap: RETIRED=%h", RETIRED);
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, 1'b1, SEL_ALU, 16'h0, 16'h4444, 3'd4, 1'b0); step();
        RADDRA = 3'd4; #1;
        n_checks++; if (RDATAA !== 16'h4444) begin n_fail++; $display("FAIL rmw_pre got %h exp 4444", RDATAA); end
        drive(1'b1, 1'b1, SEL_ALU, 16'h0, 16'h7777, 3'd4, 1'b1); step();
        drive(1'b0, 1'b0, SEL_ALU, 16'h0, 16'h0, 3'd0, 1'b0); #1;
        n_checks++; if (RDATAA !== 16'h0) begin n_fail++; $display("FAIL rmw_reg4 got %h exp 0000", RDATAA); end
        n_checks++; if (WBEN !== 1'b0) begin n_fail++; $display("FAIL rmw_wben got %0b exp 0", WBEN); end
        n_checks++; if (RETIRED !== 16'h0) begin n_fail++; $display("FAIL rmw_retired got %h exp 0000", RETIRED); end
        step(); #1;
        n_checks++; if (RDATAA !== 16'h0 || WBEN !== 1'b0) begin n_fail++; $display("FAIL rmw_no_replay got %h/%0b exp 0000/0", RDATAA, WBEN); end
        $display("reset mid-write: r4=%h RETIRED=%h", RDATAA, RETIRED);
    endtask

    initial begin
        RESET = 1'b1; RADDRA = '0; RADDRB = '0;
        bus.WBVALID = 1'b0; bus.REGWRITE = 1'b0; bus.ALUMEMSIG = 1'b0;
        bus.MEMDATA = '0; bus.ALUDATA = '0; bus.WBREG = '0;
        test_reset();
        test_alu_write();
        test_load_write();
        test_r0_protect();
        test_same_cycle();
        test_back_to_back();
        test_bubbles_wrap();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
